// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges ALU and long-latency results onto one write port, R15 goes to the PC port.
// Latency: ALU result 1 cycle to WE; long-latency result at least 2 cycles from handshake, via the FIFO.
// Backpressure: ALU is never stalled; long-latency unit sees lu_ready low when the FIFO is full or in reset.
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,

    // single-cycle ALU result, no backpressure
    input  logic                          alu_valid,
    input  logic [3:0]                    alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_result,

    // long-latency unit result, valid/ready handshake
    input  logic                          lu_valid,
    input  logic [3:0]                    lu_rd,
    input  logic [DATA_WIDTH-1:0]         lu_result,
    output logic                          lu_ready,

    // issue / decode side of the scoreboard
    input  logic                          issue_valid,
    input  logic [3:0]                    issue_rd,
    input  logic [3:0]                    rs1,
    input  logic [3:0]                    rs2,
    output logic                          hazard,

    // register-file write port
    output logic                          WE,
    output logic [3:0]                    destination_register,
    output logic [DATA_WIDTH-1:0]         WD,

    // PC update port for writes aimed at R15
    output logic                          pc_write,
    output logic [DATA_WIDTH-1:0]         pc_value,

    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] PC_REG = 4'hF;

    // ------------------------------------------------------------------
    // Long-latency result buffer
    // ------------------------------------------------------------------
    logic [3:0]            fifo_rd_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_dat_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;

    logic [3:0]            head_rd;
    logic [DATA_WIDTH-1:0] head_dat;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_dat   = fifo_dat_q[rd_ptr_q];

    // Ready is held low during reset so no result is accepted and then discarded.
    assign lu_ready  = !fifo_full && !reset;
    assign fifo_push = lu_valid && lu_ready;

    // ------------------------------------------------------------------
    // Writeback selection and output stage
    // ------------------------------------------------------------------
    logic                  sel_vld;
    logic [3:0]            sel_rd;
    logic [DATA_WIDTH-1:0] sel_dat;

    logic                  we_q,       we_d;
    logic [3:0]            dest_q,     dest_d;
    logic [DATA_WIDTH-1:0] wd_q,       wd_d;
    logic                  pc_write_q, pc_write_d;
    logic [DATA_WIDTH-1:0] pc_value_q, pc_value_d;

    // ------------------------------------------------------------------
    // Pending-destination scoreboard
    // ------------------------------------------------------------------
    logic [15:0] busy_q, busy_d;

    // Fixed priority: ALU first (it cannot wait), otherwise drain the FIFO head.
    // The pop looks at the registered count, so an entry pushed this cycle is
    // not visible until the next one.
    always_comb begin
        sel_vld  = 1'b0;
        sel_rd   = '0;
        sel_dat  = '0;
        fifo_pop = 1'b0;
        if (alu_valid) begin
            sel_vld = 1'b1;
            sel_rd  = alu_rd;
            sel_dat = alu_result;
        end else if (!fifo_empty) begin
            sel_vld  = 1'b1;
            sel_rd   = head_rd;
            sel_dat  = head_dat;
            fifo_pop = 1'b1;
        end
    end

    // Next output values: R15 is diverted to the PC port, idle cycles hold address/data.
    always_comb begin
        we_d       = 1'b0;
        pc_write_d = 1'b0;
        dest_d     = dest_q;
        wd_d       = wd_q;
        pc_value_d = pc_value_q;
        if (sel_vld) begin
            if (sel_rd == PC_REG) begin
                pc_write_d = 1'b1;
                pc_value_d = sel_dat;
            end else begin
                we_d   = 1'b1;
                dest_d = sel_rd;
                wd_d   = sel_dat;
            end
        end
    end

    // Next FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard update: retire the popped entry, then apply the issue so a
    // same-register set in the same cycle wins. ALU writes are not tracked.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    // Hazard looks only at the registered busy bits: a same-cycle retire is not bypassed.
    assign hazard = busy_q[rs1] | busy_q[rs2] | busy_q[issue_rd];

    // FIFO storage; contents need no reset because the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_rd_q[wr_ptr_q]  <= lu_rd;
            fifo_dat_q[wr_ptr_q] <= lu_result;
        end
    end

    // FIFO control and scoreboard registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    // Write-port and PC-port output registers, stable by the following falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            dest_q     <= '0;
            wd_q       <= '0;
            pc_write_q <= 1'b0;
            pc_value_q <= '0;
        end else begin
            we_q       <= we_d;
            dest_q     <= dest_d;
            wd_q       <= wd_d;
            pc_write_q <= pc_write_d;
            pc_value_q <= pc_value_d;
        end
    end

    assign WE                   = we_q;
    assign destination_register = dest_q;
    assign WD                   = wd_q;
    assign pc_write             = pc_write_q;
    assign pc_value             = pc_value_q;
    assign fifo_count           = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed vector table, a mid-operation reset sequence,
// and randomized traffic checked against a queue-based reference model.
// Inputs change on the falling edge; registered outputs are sampled 1 ns after the rising edge.
module tb_writeback_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          alu_valid;
    logic [3:0]    alu_rd;
    logic [DW-1:0] alu_result;
    logic          lu_valid;
    logic [3:0]    lu_rd;
    logic [DW-1:0] lu_result;
    logic          lu_ready;
    logic          issue_valid;
    logic [3:0]    issue_rd;
    logic [3:0]    rs1;
    logic [3:0]    rs2;
    logic          hazard;
    logic          WE;
    logic [3:0]    destination_register;
    logic [DW-1:0] WD;
    logic          pc_write;
    logic [DW-1:0] pc_value;
    logic [2:0]    fifo_count;

    writeback_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .alu_valid            (alu_valid),
        .alu_rd               (alu_rd),
        .alu_result           (alu_result),
        .lu_valid             (lu_valid),
        .lu_rd                (lu_rd),
        .lu_result            (lu_result),
        .lu_ready             (lu_ready),
        .issue_valid          (issue_valid),
        .issue_rd             (issue_rd),
        .rs1                  (rs1),
        .rs2                  (rs2),
        .hazard               (hazard),
        .WE                   (WE),
        .destination_register (destination_register),
        .WD                   (WD),
        .pc_write             (pc_write),
        .pc_value             (pc_value),
        .fifo_count           (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [3:0] ard, input logic [31:0] ares,
                         input logic lv, input logic [3:0] lrd, input logic [31:0] lres,
                         input logic iv, input logic [3:0] ird, input logic [3:0] s1, input logic [3:0] s2);
        @(negedge clk);
        reset       = r;
        alu_valid   = av;
        alu_rd      = ard;
        alu_result  = ares;
        lu_valid    = lv;
        lu_rd       = lrd;
        lu_result   = lres;
        issue_valid = iv;
        issue_rd    = ird;
        rs1         = s1;
        rs2         = s2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    // hz: expected pre-edge hazard (2 = not checked); rdy: pre-edge lu_ready;
    // remaining expectations are post-edge register outputs.
    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  ard;
        logic [31:0] ares;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] lres;
        logic        iv;
        logic [3:0]  ird;
        logic [3:0]  s1;
        logic [3:0]  s2;
        int          hz;
        logic        rdy;
        logic        we;
        logic [3:0]  rd;
        logic [31:0] wd;
        logic        pcw;
        logic [31:0] pcv;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(int rst, int av, int ard, int ares, int lv, int lrd, int lres,
                                int iv, int ird, int s1, int s2,
                                int hz, int rdy, int we, int rd, int wd, int pcw, int pcv, int cnt);
        vec_t v;
        v.rst = 1'(rst);  v.av = 1'(av);  v.ard = 4'(ard);  v.ares = 32'(ares);
        v.lv = 1'(lv);    v.lrd = 4'(lrd); v.lres = 32'(lres);
        v.iv = 1'(iv);    v.ird = 4'(ird); v.s1 = 4'(s1);  v.s2 = 4'(s2);
        v.hz = hz;        v.rdy = 1'(rdy);
        v.we = 1'(we);    v.rd = 4'(rd);   v.wd = 32'(wd);
        v.pcw = 1'(pcw);  v.pcv = 32'(pcv); v.cnt = 3'(cnt);
        return v;
    endfunction

    localparam int NV = 35;
    vec_t tbl [NV];

    // reference model state
    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t        mq [$];
    ent_t        me;
    logic [15:0] mbusy;
    logic        m_we, m_pcw, m_haz, m_rdy, m_have;
    logic [3:0]  m_rd, m_erd;
    logic [31:0] m_wd, m_pcv, m_ed;

    logic        r_r, r_av, r_lv, r_iv;
    logic [3:0]  r_ard, r_lrd, r_ird, r_s1, r_s2;
    logic [31:0] r_ares, r_lres;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_result = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;

        //             rst av rd res    lv lrd lres  iv ird s1 s2   hz rdy  we rd wd     pcw pcv   cnt
        tbl[0]  = mk(1, 1, 3, 'hAA,  0, 0, 0,     0, 0, 0, 0,   2, 0,   0, 0, 0,     0, 0,    0);
        tbl[1]  = mk(1, 1, 3, 'hAA,  0, 0, 0,     0, 0, 0, 0,   0, 0,   0, 0, 0,     0, 0,    0);
        tbl[2]  = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   0, 0, 0,     0, 0,    0);
        tbl[3]  = mk(0, 1, 3, 'hAA,  0, 0, 0,     0, 0, 0, 0,   0, 1,   1, 3, 'hAA,  0, 0,    0);
        tbl[4]  = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   0, 3, 'hAA,  0, 0,    0);
        tbl[5]  = mk(0, 1, 1, 'h100, 1, 5, 'h11,  0, 0, 0, 0,   0, 1,   1, 1, 'h100, 0, 0,    1);
        tbl[6]  = mk(0, 1, 1, 'h101, 1, 6, 'h22,  0, 0, 0, 0,   0, 1,   1, 1, 'h101, 0, 0,    2);
        tbl[7]  = mk(0, 1, 1, 'h102, 0, 0, 0,     0, 0, 0, 0,   0, 1,   1, 1, 'h102, 0, 0,    2);
        tbl[8]  = mk(0, 1, 1, 'h103, 0, 0, 0,     0, 0, 0, 0,   0, 1,   1, 1, 'h103, 0, 0,    2);
        tbl[9]  = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   1, 5, 'h11,  0, 0,    1);
        tbl[10] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   1, 6, 'h22,  0, 0,    0);
        tbl[11] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   0, 6, 'h22,  0, 0,    0);
        tbl[12] = mk(0, 1, 2, 'h200, 1, 8, 'h31,  0, 0, 0, 0,   0, 1,   1, 2, 'h200, 0, 0,    1);
        tbl[13] = mk(0, 1, 2, 'h201, 1, 9, 'h32,  0, 0, 0, 0,   0, 1,   1, 2, 'h201, 0, 0,    2);
        tbl[14] = mk(0, 1, 2, 'h202, 1, 10,'h33,  0, 0, 0, 0,   0, 1,   1, 2, 'h202, 0, 0,    3);
        tbl[15] = mk(0, 1, 2, 'h203, 1, 11,'h34,  0, 0, 0, 0,   0, 1,   1, 2, 'h203, 0, 0,    4);
        tbl[16] = mk(0, 1, 2, 'h204, 1, 12,'h35,  0, 0, 0, 0,   0, 0,   1, 2, 'h204, 0, 0,    4);
        tbl[17] = mk(0, 0, 0, 0,     1, 12,'h35,  0, 0, 0, 0,   0, 0,   1, 8, 'h31,  0, 0,    3);
        tbl[18] = mk(0, 0, 0, 0,     1, 12,'h35,  0, 0, 0, 0,   0, 1,   1, 9, 'h32,  0, 0,    3);
        tbl[19] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   1, 10,'h33,  0, 0,    2);
        tbl[20] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   1, 11,'h34,  0, 0,    1);
        tbl[21] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   1, 12,'h35,  0, 0,    0);
        tbl[22] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   0, 12,'h35,  0, 0,    0);
        tbl[23] = mk(0, 1, 15,'h40,  0, 0, 0,     0, 0, 0, 0,   0, 1,   0, 12,'h35,  1, 'h40, 0);
        tbl[24] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,   0, 1,   0, 12,'h35,  0, 'h40, 0);
        tbl[25] = mk(0, 0, 0, 0,     0, 0, 0,     1, 7, 0, 0,   0, 1,   0, 12,'h35,  0, 'h40, 0);
        tbl[26] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 7, 0,   1, 1,   0, 12,'h35,  0, 'h40, 0);
        tbl[27] = mk(0, 0, 0, 0,     1, 7, 'h77,  0, 0, 7, 0,   1, 1,   0, 12,'h35,  0, 'h40, 1);
        tbl[28] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 7, 0,   1, 1,   1, 7, 'h77,  0, 'h40, 0);
        tbl[29] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 7, 0,   0, 1,   0, 7, 'h77,  0, 'h40, 0);
        tbl[30] = mk(0, 0, 0, 0,     0, 0, 0,     1, 7, 0, 0,   0, 1,   0, 7, 'h77,  0, 'h40, 0);
        tbl[31] = mk(0, 0, 0, 0,     1, 7, 'h78,  0, 0, 0, 0,   0, 1,   0, 7, 'h77,  0, 'h40, 1);
        tbl[32] = mk(0, 0, 0, 0,     0, 0, 0,     1, 7, 0, 0,   1, 1,   1, 7, 'h78,  0, 'h40, 0);
        tbl[33] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 7, 0,   1, 1,   0, 7, 'h78,  0, 'h40, 0);
        tbl[34] = mk(0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 7,   1, 1,   0, 7, 'h78,  0, 'h40, 0);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].ares, tbl[i].lv, tbl[i].lrd, tbl[i].lres,
                  tbl[i].iv, tbl[i].ird, tbl[i].s1, tbl[i].s2);
            #1;
            if (tbl[i].hz != 2) chk($sformatf("row%0d hazard", i), 32'(hazard), 32'(tbl[i].hz));
            chk($sformatf("row%0d lu_ready", i), 32'(lu_ready), 32'(tbl[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("row%0d WE", i), 32'(WE), 32'(tbl[i].we));
            chk($sformatf("row%0d rd", i), 32'(destination_register), 32'(tbl[i].rd));
            chk($sformatf("row%0d WD", i), WD, tbl[i].wd);
            chk($sformatf("row%0d pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
            chk($sformatf("row%0d pc_value", i), pc_value, tbl[i].pcv);
            chk($sformatf("row%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
        end

        // ---------------- reset in the middle of operation ----------------
        drive(1'b0, 1'b1, 4'd1, 32'h500, 1'b1, 4'd4, 32'h44, 1'b1, 4'd9, 4'd0, 4'd0);
        @(posedge clk); #1;
        chk("midrst count1", 32'(fifo_count), 32'd1);
        drive(1'b0, 1'b1, 4'd1, 32'h501, 1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 4'd9, 4'd0);
        #1;
        chk("midrst hazard before", 32'(hazard), 32'd1);
        @(posedge clk); #1;
        chk("midrst count2", 32'(fifo_count), 32'd2);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd9, 4'd7);
        #1;
        chk("midrst lu_ready in reset", 32'(lu_ready), 32'd0);
        @(posedge clk); #1;
        chk("midrst WE", 32'(WE), 32'd0);
        chk("midrst count0", 32'(fifo_count), 32'd0);
        chk("midrst WD", WD, 32'd0);
        chk("midrst pc_value", pc_value, 32'd0);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd9, 4'd7);
        #1;
        chk("midrst hazard after", 32'(hazard), 32'd0);
        chk("midrst lu_ready after", 32'(lu_ready), 32'd1);
        @(posedge clk); #1;
        chk("midrst no stale write", 32'(WE | pc_write), 32'd0);
        idle();
        @(posedge clk); #1;
        chk("midrst still idle", 32'(WE | pc_write), 32'd0);

        // ---------------- randomized traffic vs reference model ----------------
        mq.delete();
        mbusy = '0;
        m_we = 1'b0; m_pcw = 1'b0; m_rd = '0; m_wd = '0; m_pcv = '0;
        for (int n = 0; n < 1500; n++) begin
            r_r    = (n == 0) || ($urandom_range(99) == 0);
            r_av   = 1'($urandom_range(1));
            r_ard  = 4'($urandom_range(15));
            r_ares = $urandom;
            r_lv   = ($urandom_range(9) < 6);
            r_lrd  = 4'($urandom_range(15));
            r_lres = $urandom;
            r_ird  = 4'($urandom_range(15));
            r_s1   = 4'($urandom_range(15));
            r_s2   = 4'($urandom_range(15));
            m_haz  = mbusy[r_s1] | mbusy[r_s2] | mbusy[r_ird];
            r_iv   = !m_haz && ($urandom_range(3) == 0);
            m_rdy  = !r_r && (mq.size() < DEPTH);

            drive(r_r, r_av, r_ard, r_ares, r_lv, r_lrd, r_lres, r_iv, r_ird, r_s1, r_s2);
            #1;
            if (n > 0) chk($sformatf("rnd%0d hazard", n), 32'(hazard), 32'(m_haz));
            chk($sformatf("rnd%0d lu_ready", n), 32'(lu_ready), 32'(m_rdy));

            if (r_r) begin
                mq.delete();
                mbusy = '0;
                m_we = 1'b0; m_pcw = 1'b0; m_rd = '0; m_wd = '0; m_pcv = '0;
            end else begin
                m_have = 1'b0;
                m_erd  = '0;
                m_ed   = '0;
                if (r_av) begin
                    m_have = 1'b1; m_erd = r_ard; m_ed = r_ares;
                end else if (mq.size() > 0) begin
                    me = mq.pop_front();
                    m_have = 1'b1; m_erd = me.rd; m_ed = me.d;
                    mbusy[me.rd] = 1'b0;
                end
                if (r_iv) mbusy[r_ird] = 1'b1;
                if (r_lv && m_rdy) mq.push_back('{rd: r_lrd, d: r_lres});
                m_we  = 1'b0;
                m_pcw = 1'b0;
                if (m_have) begin
                    if (m_erd == 4'hF) begin
                        m_pcw = 1'b1; m_pcv = m_ed;
                    end else begin
                        m_we = 1'b1; m_rd = m_erd; m_wd = m_ed;
                    end
                end
            end

            @(posedge clk); #1;
            chk($sformatf("rnd%0d WE", n), 32'(WE), 32'(m_we));
            chk($sformatf("rnd%0d rd", n), 32'(destination_register), 32'(m_rd));
            chk($sformatf("rnd%0d WD", n), WD, m_wd);
            chk($sformatf("rnd%0d pc_write", n), 32'(pc_write), 32'(m_pcw));
            chk($sformatf("rnd%0d pc_value", n), pc_value, m_pcv);
            chk($sformatf("rnd%0d fifo_count", n), 32'(fifo_count), 32'(mq.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Drives the single write port of the register file: WE, destination_register and WD.
- Merges two result sources:
  - the single-cycle ALU, which has no backpressure;
  - the multi-cycle long-latency unit (divider/EX path), which uses a valid/ready handshake.
- Buffers long-latency results in a small FIFO.
- Keeps a pending-destination scoreboard so issue logic can stall on RAW/WAW hazards.
- Redirects writes to R15 onto a PC-update port instead of the register file.

Parameters:
- DATA_WIDTH, 32, width of result and write-data paths.
- FIFO_DEPTH, 4, long-latency result buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; must be accepted.
- alu_rd  in  4  ALU destination register.
- alu_result  in  DATA_WIDTH  ALU result.
- lu_valid  in  1  long-latency result offered.
- lu_rd  in  4  long-latency destination register.
- lu_result  in  DATA_WIDTH  long-latency result.
- lu_ready  out  1  FIFO can accept; transfer when lu_valid&&lu_ready.
- issue_valid  in  1  a long-latency op is issued this cycle.
- issue_rd  in  4  destination of the issued op.
- rs1, rs2  in  4 each  source registers of the instruction in decode.
- hazard  out  1  combinational; busy[rs1]|busy[rs2]|busy[issue_rd].
- WE  out  1  register-file write enable (registered).
- destination_register  out  4  register-file write address (registered).
- WD  out  DATA_WIDTH  register-file write data (registered).
- pc_write  out  1  one-cycle pulse: write targeted R15 (registered).
- pc_value  out  DATA_WIDTH  new PC value, valid when pc_write.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - WE, pc_write, destination_register, WD, pc_value are 0.
  - FIFO is empty; fifo_count is 0; all 16 busy bits are 0.
  - lu_ready is 0 while reset is high.
  - Reset mid-operation discards all buffered results and pending scoreboard state.
- Output stage:
  - All write-port outputs are registered on posedge. They are therefore stable at the following negedge, where the register file samples.
  - At most one write is emitted per cycle.
- Selection each cycle (fixed priority):
  - alu_valid: emit the ALU entry. Latency is 1 cycle, alu_valid → WE.
  - else, FIFO non-empty: pop the head and emit it.
  - else: WE=0, pc_write=0; destination_register, WD and pc_value hold their last values.
- R15 redirect:
  - If the selected rd==4'hF: pc_write=1, pc_value=data, WE=0.
  - Otherwise: WE=1, destination_register=rd, WD=data, pc_write=0.
- FIFO:
  - lu_ready = !full && !reset.
  - A push while full is impossible by the handshake.
  - Push and pop in the same cycle is allowed when not full; count is unchanged.
  - An entry pushed in cycle N can be popped no earlier than N+1, so minimum long-latency writeback latency is 2 cycles from handshake to WE.
  - Pointers wrap modulo FIFO_DEPTH. Ordering is strict FIFO.
  - Continuous alu_valid starves the FIFO; this is legal.
  - Correctness across starvation is guaranteed by the scoreboard, not by timing.
- Scoreboard:
  - busy[issue_rd] is set on issue_valid.
  - busy[rd] is cleared when a FIFO entry is emitted, whether through WE or pc_write.
  - ALU writes never touch busy bits.
  - Set and clear of the same register in the same cycle: set wins.
  - hazard uses the current busy state, not the same-cycle clear, so there is no bypass.
  - Upstream never issues while hazard=1.
- fifo_count reflects the post-edge occupancy.

Test Plan:
- Reset: hold reset 2 cycles with alu_valid=1 → WE=0, pc_write=0, lu_ready=0, fifo_count=0. After release, lu_ready=1.
- ALU write: alu_valid=1, alu_rd=3, alu_result=0x0000_00AA at cycle N → cycle N+1 WE=1, destination_register=3, WD=0xAA. Cycle N+2 WE=0.
- FIFO ordering and starvation:
  - Push lu entries (rd=5,0x11), (rd=6,0x22) while alu_valid=1 for 4 cycles → no lu writes during those cycles; fifo_count=2.
  - Then alu_valid=0 → writes rd5/0x11 then rd6/0x22 in consecutive cycles.
- Full backpressure: push FIFO_DEPTH entries with alu_valid held high → lu_ready=0 and fifo_count=4. Drop alu_valid → one pop, then lu_ready=1.
- R15 redirect: alu_valid=1, alu_rd=15, alu_result=0x40 → next cycle pc_write=1, pc_value=0x40, WE=0.
- Scoreboard:
  - issue_valid with issue_rd=7; rs1=7 → hazard=1.
  - lu entry rd=7 emitted → hazard=0 the cycle after WE.
  - Issue rd=7 on the same cycle rd=7 retires → busy[7] remains 1.
